// File: rtl/ysyx_23060072_wbu.sv
// Write-back unit: retires EX results and aligned/extended load data onto the
// register file write port, one retire pulse per instruction.
module ysyx_23060072_wbu #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_rd_we_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic              ex_is_load_i,
    input  logic [2:0]        ex_load_op_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [REG_AW-1:0] wb_reg_addr_o,
    output logic              wb_flag_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              retire_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic                we_q, we_d;
    logic [2:0]          op_q, op_d;
    logic [1:0]          off_q, off_d;
    logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
    logic                wb_flag_q, wb_flag_d;
    logic [DATA_W-1:0]   wb_wdata_q, wb_wdata_d;
    logic                retire_q, retire_d;

    logic [BYTE_W-1:0]   byte_sel;
    logic [HALF_W-1:0]   half_sel;
    logic [DATA_W-1:0]   load_data;

    // Lane selection and extension of the pending load's read data
    always_comb begin
        byte_sel = mem_rdata_i[7:0];
        case (off_q)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (op_q)
            3'b000:  load_data = {{(DATA_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
            3'b001:  load_data = {{(DATA_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
            3'b100:  load_data = DATA_W'(byte_sel);
            3'b101:  load_data = DATA_W'(half_sel);
            default: load_data = mem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        we_d       = we_q;
        op_d       = op_q;
        off_d      = off_q;
        wb_addr_d  = wb_addr_q;
        wb_wdata_d = wb_wdata_q;
        wb_flag_d  = 1'b0;
        retire_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (ex_is_load_i) begin
                        rd_d    = ex_rd_i;
                        we_d    = ex_rd_we_i;
                        op_d    = ex_load_op_i;
                        off_d   = ex_result_i[1:0];
                        state_d = LOAD_WAIT;
                    end else begin
                        wb_flag_d  = ex_rd_we_i & (ex_rd_i != '0);
                        wb_addr_d  = ex_rd_i;
                        wb_wdata_d = ex_result_i;
                        retire_d   = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid_i) begin
                    wb_flag_d  = we_q & (rd_q != '0);
                    wb_addr_d  = rd_q;
                    wb_wdata_d = load_data;
                    retire_d   = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            rd_q       <= '0;
            we_q       <= 1'b0;
            op_q       <= '0;
            off_q      <= '0;
            wb_addr_q  <= '0;
            wb_flag_q  <= 1'b0;
            wb_wdata_q <= '0;
            retire_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            op_q       <= op_d;
            off_q      <= off_d;
            wb_addr_q  <= wb_addr_d;
            wb_flag_q  <= wb_flag_d;
            wb_wdata_q <= wb_wdata_d;
            retire_q   <= retire_d;
        end
    end

    assign ex_ready_o    = ready_q;
    assign wb_reg_addr_o = wb_addr_q;
    assign wb_flag_o     = wb_flag_q;
    assign wb_wdata_o    = wb_wdata_q;
    assign retire_o      = retire_q;

endmodule

// File: tb/tb_ysyx_23060072_wbu.sv
// Scoreboard bench for ysyx_23060072_wbu: stimulus pushes expected writes,
// a negedge monitor pops and compares on every retire pulse.
module tb_ysyx_23060072_wbu;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_rd_i;
    logic        ex_rd_we_i;
    logic [31:0] ex_result_i;
    logic        ex_is_load_i;
    logic [2:0]  ex_load_op_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [4:0]  wb_reg_addr_o;
    logic        wb_flag_o;
    logic [31:0] wb_wdata_o;
    logic        retire_o;

    typedef struct packed {
        logic        flag;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ysyx_23060072_wbu #(.DATA_W(32), .REG_AW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_rd_i       (ex_rd_i),
        .ex_rd_we_i    (ex_rd_we_i),
        .ex_result_i   (ex_result_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_load_op_i  (ex_load_op_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .wb_reg_addr_o (wb_reg_addr_o),
        .wb_flag_o     (wb_flag_o),
        .wb_wdata_o    (wb_wdata_o),
        .retire_o      (retire_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every retire must match the oldest expected write, in order
    always @(negedge clk) begin
        exp_t e;
        if (retire_o) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_retire: got retire with flag=%0b addr=%0d data=0x%08h expected none",
                         wb_flag_o, wb_reg_addr_o, wb_wdata_o);
            end else begin
                e = q.pop_front();
                check("wb_flag", 32'(wb_flag_o), 32'(e.flag));
                if (e.flag) begin
                    check("wb_addr", 32'(wb_reg_addr_o), 32'(e.addr));
                    check("wb_data", wb_wdata_o, e.data);
                end
            end
        end else begin
            check("flag_without_retire", 32'(wb_flag_o), 32'd0);
        end
    end

    // Wait (bounded) for ready, then hold one instruction on EX for its accept edge
    task automatic issue(input logic [4:0] rd, input logic we, input logic [31:0] res,
                         input logic ld, input logic [2:0] op);
        int guard = 0;
        while (!ex_ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_issue", 32'(ex_ready_o), 32'd1);
        ex_valid_i   = 1'b1;
        ex_rd_i      = rd;
        ex_rd_we_i   = we;
        ex_result_i  = res;
        ex_is_load_i = ld;
        ex_load_op_i = op;
        @(posedge clk); #1;
        ex_valid_i   = 1'b0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic we, input logic [31:0] res);
        q.push_back('{flag: we && (rd != 5'd0), addr: rd, data: res});
        issue(rd, we, res, 1'b0, 3'b010);
        check("alu_retire_next_cycle", 32'(retire_o), 32'd1);
        check("alu_ready", 32'(ex_ready_o), 32'd1);
    endtask

    task automatic load(input logic [4:0] rd, input logic we, input logic [31:0] addr,
                        input logic [2:0] op, input logic [31:0] rdata, input logic [31:0] exp,
                        input int delay, input logic hold_valid);
        q.push_back('{flag: we && (rd != 5'd0), addr: rd, data: exp});
        issue(rd, we, addr, 1'b1, op);
        if (hold_valid) begin
            ex_valid_i   = 1'b1;
            ex_is_load_i = 1'b0;
            ex_rd_i      = 5'd9;
            ex_result_i  = 32'hBAD0_0BAD;
        end
        check("load_ready_low", 32'(ex_ready_o), 32'd0);
        check("load_no_early_retire", 32'(retire_o), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check("load_wait_ready_low", 32'(ex_ready_o), 32'd0);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        ex_valid_i   = 1'b0;
        check("load_retire", 32'(retire_o), 32'd1);
        check("load_ready_back", 32'(ex_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        ex_valid_i   = 1'b0;
        ex_rd_i      = '0;
        ex_rd_we_i   = 1'b0;
        ex_result_i  = '0;
        ex_is_load_i = 1'b0;
        ex_load_op_i = '0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(ex_ready_o), 32'd1);
        check("reset_flag", 32'(wb_flag_o), 32'd0);
        check("reset_retire", 32'(retire_o), 32'd0);
        check("reset_addr", 32'(wb_reg_addr_o), 32'd0);
        check("reset_data", wb_wdata_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU write
        alu(5'd5, 1'b1, 32'h1234_5678);

        // Byte / half / word extraction
        load(5'd1, 1'b1, 32'h0000_1003, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80, 0, 1'b0);
        load(5'd2, 1'b1, 32'h0000_1003, 3'b100, 32'h80FF_0000, 32'h0000_0080, 1, 1'b0);
        load(5'd3, 1'b1, 32'h0000_2002, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001, 2, 1'b0);
        load(5'd4, 1'b1, 32'h0000_2000, 3'b101, 32'h8001_7FFF, 32'h0000_7FFF, 0, 1'b0);
        load(5'd6, 1'b1, 32'h0000_2000, 3'b010, 32'h8001_7FFF, 32'h8001_7FFF, 0, 1'b0);
        load(5'd7, 1'b1, 32'h0000_2003, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001, 0, 1'b0);
        load(5'd8, 1'b1, 32'h0000_3002, 3'b000, 32'h80FF_0000, 32'hFFFF_FFFF, 0, 1'b0);
        load(5'd10, 1'b1, 32'h0000_3001, 3'b011, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 1'b0);
        load(5'd11, 1'b1, 32'h0000_3001, 3'b101, 32'hCAFE_F00D, 32'h0000_F00D, 0, 1'b0);

        // Stray rvalid in IDLE, then a long wait with EX valid held
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_1111;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        check("stray_rvalid_no_retire", 32'(retire_o), 32'd0);
        check("stray_rvalid_ready", 32'(ex_ready_o), 32'd1);
        load(5'd12, 1'b1, 32'h0000_4000, 3'b010, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 5, 1'b1);
        @(posedge clk); #1;
        check("held_valid_not_accepted", 32'(retire_o), 32'd0);

        // x0 and we=0 retire without writing; three back-to-back ALU writes
        alu(5'd0, 1'b1, 32'hDEAD_BEEF);
        check("x0_flag_low", 32'(wb_flag_o), 32'd0);
        alu(5'd13, 1'b0, 32'h0000_0042);
        alu(5'd14, 1'b1, 32'h0000_0001);
        alu(5'd15, 1'b1, 32'h0000_0002);
        alu(5'd31, 1'b1, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        // Reset during LOAD_WAIT drops the load
        issue(5'd20, 1'b1, 32'h0000_5000, 1'b1, 3'b010);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_wait_ready", 32'(ex_ready_o), 32'd1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h7777_7777;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        check("rst_drop_retire", 32'(retire_o), 32'd0);
        check("rst_drop_flag", 32'(wb_flag_o), 32'd0);
        check("rst_drop_ready", 32'(ex_ready_o), 32'd1);
        check("rst_drop_addr", 32'(wb_reg_addr_o), 32'd0);
        check("rst_drop_data", wb_wdata_o, 32'd0);

        // Back to normal after reset, then a load right after a load
        alu(5'd21, 1'b1, 32'h0BAD_CAFE);
        load(5'd22, 1'b1, 32'h0000_6001, 3'b100, 32'h0000_EE00, 32'h0000_00EE, 0, 1'b0);
        load(5'd23, 1'b1, 32'h0000_6000, 3'b000, 32'h0000_0011, 32'h0000_0011, 0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
